// File: rtl/congestion_detector.sv
// Traffic congestion detector: synchronised, debounced loop-detector pulses are
// counted per fixed window and fed to a hysteretic FSM with a minimum hold time.
module congestion_detector #(
  parameter int WINDOW     = 10,
  parameter int ON_THRESH  = 8,
  parameter int OFF_THRESH = 3,
  parameter int HOLD_MIN   = 4,
  parameter int DEBOUNCE   = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       car_sensor,
  input  logic       enable,
  output logic       congestion,
  output logic [7:0] car_count,
  output logic       window_done,
  output logic [1:0] state_dbg
);

  localparam int WW = $clog2(WINDOW);
  localparam int HW = $clog2(HOLD_MIN + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    CLEAR     = 2'd1,
    CONGESTED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            deb_level_q, deb_level_d;
  logic            deb_prev_q, deb_prev_d;
  logic [WW-1:0]   win_q, win_d;
  logic [7:0]      acc_q, acc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            congestion_q, congestion_d;
  logic [7:0]      car_count_q, car_count_d;
  logic            window_done_q, window_done_d;

  logic            car_event;
  logic [8:0]      acc_sum;
  logic [7:0]      acc_sat;
  logic            win_close;
  logic            count_on;
  logic            count_off;
  logic            hold_done;

  // Front end runs regardless of enable so a re-enable sees a settled level.
  always_comb begin
    sync1_d = car_sensor;
    sync2_d = sync1_q;
    if (!sync2_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DW'(DEBOUNCE)) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end else begin
      deb_cnt_d = deb_cnt_q;
    end
    deb_level_d = (deb_cnt_d == DW'(DEBOUNCE));
    deb_prev_d  = deb_level_q;
  end

  assign car_event = deb_level_q & ~deb_prev_q;
  assign acc_sum   = {1'b0, acc_q} + {8'd0, car_event};
  assign acc_sat   = acc_sum[8] ? 8'hFF : acc_sum[7:0];
  assign win_close = (win_q == WW'(WINDOW - 1));
  assign count_on  = (acc_sat >= 8'(ON_THRESH));
  assign count_off = (acc_sat <= 8'(OFF_THRESH));
  assign hold_done = (hold_q >= HW'(HOLD_MIN));

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    acc_d         = acc_q;
    hold_d        = hold_q;
    congestion_d  = congestion_q;
    car_count_d   = car_count_q;
    window_done_d = 1'b0;
    if (!enable) begin
      state_d      = DISABLED;
      win_d        = '0;
      acc_d        = '0;
      hold_d       = '0;
      congestion_d = 1'b0;
    end else begin
      case (state_q)
        DISABLED: begin
          state_d = CLEAR;
          win_d   = '0;
          acc_d   = '0;
          hold_d  = '0;
        end
        CLEAR, CONGESTED: begin
          win_d = win_close ? '0 : win_q + WW'(1);
          if (win_close) begin
            car_count_d   = acc_sat;
            acc_d         = '0;
            window_done_d = 1'b1;
            if (state_q == CLEAR) begin
              if (count_on) begin
                state_d      = CONGESTED;
                congestion_d = 1'b1;
                hold_d       = '0;
              end
            end else if (hold_done && count_off) begin
              state_d      = CLEAR;
              congestion_d = 1'b0;
              hold_d       = '0;
            end else if (!hold_done) begin
              hold_d = hold_q + HW'(1);
            end
          end else begin
            acc_d = acc_sat;
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= DISABLED;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      deb_cnt_q     <= '0;
      deb_level_q   <= 1'b0;
      deb_prev_q    <= 1'b0;
      win_q         <= '0;
      acc_q         <= '0;
      hold_q        <= '0;
      congestion_q  <= 1'b0;
      car_count_q   <= '0;
      window_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_cnt_q     <= deb_cnt_d;
      deb_level_q   <= deb_level_d;
      deb_prev_q    <= deb_prev_d;
      win_q         <= win_d;
      acc_q         <= acc_d;
      hold_q        <= hold_d;
      congestion_q  <= congestion_d;
      car_count_q   <= car_count_d;
      window_done_q <= window_done_d;
    end
  end

  assign congestion  = congestion_q;
  assign car_count   = car_count_q;
  assign window_done = window_done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_congestion_detector.sv
// Bench for congestion_detector: three parameterisations share stimulus; a table of
// per-window vectors feeds an expected queue checked on every window_done pulse.
module tb_congestion_detector;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       car_sensor = 1'b0;
  logic       enable = 1'b0;

  logic       cong_a, wd_a, cong_b, wd_b, cong_c, wd_c;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] st_a, st_b, st_c;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  congestion_detector dut_a (
    .clock(clock), .reset_n(reset_n), .car_sensor(car_sensor), .enable(enable),
    .congestion(cong_a), .car_count(cnt_a), .window_done(wd_a), .state_dbg(st_a)
  );

  congestion_detector #(.WINDOW(40)) dut_b (
    .clock(clock), .reset_n(reset_n), .car_sensor(car_sensor), .enable(enable),
    .congestion(cong_b), .car_count(cnt_b), .window_done(wd_b), .state_dbg(st_b)
  );

  congestion_detector #(.WINDOW(1000), .DEBOUNCE(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .car_sensor(car_sensor), .enable(enable),
    .congestion(cong_c), .car_count(cnt_c), .window_done(wd_c), .state_dbg(st_c)
  );

  // ---------------- vector table ----------------
  typedef struct {
    int         sel;
    bit         rst;
    int         npulse;
    int         plen;
    logic [7:0] exp_cnt;
    logic       exp_cg;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_errs = 0;
  int         sel = 0;
  int         w_sel = 10;
  int         deb_sel = 2;
  bit         mon_on = 1'b0;

  logic       mon_wd, mon_cg, wd_prev;
  logic [7:0] mon_cc;
  logic [8:0] mon_exp;

  always_comb begin
    case (sel)
      0:       begin mon_wd = wd_a; mon_cg = cong_a; mon_cc = cnt_a; end
      1:       begin mon_wd = wd_b; mon_cg = cong_b; mon_cc = cnt_b; end
      default: begin mon_wd = wd_c; mon_cg = cong_c; mon_cc = cnt_c; end
    endcase
  end

  // ---------------- scoreboard ----------------
  initial wd_prev = 1'b0;
  always @(negedge clock) begin
    if (mon_on && mon_wd) begin
      n_checks++;
      if (wd_prev) begin
        n_errs++;
        $display("FAIL window_done_width got=two-cycle pulse exp=one-cycle pulse");
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errs++;
        $display("FAIL window_unexpected got={cg,cnt}=%h exp=no window close", {mon_cg, mon_cc});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mon_cg, mon_cc} !== mon_exp) begin
          n_errs++;
          $display("FAIL window_result dut=%0d got cg=%0d cnt=%0d exp cg=%0d cnt=%0d",
                   sel, mon_cg, mon_cc, mon_exp[8], mon_exp[7:0]);
        end
      end
    end
    wd_prev <= mon_wd;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic add_vec(input int s, input bit r, input int n, input int p,
                         input int c, input bit g);
    vec_t v;
    v.sel = s; v.rst = r; v.npulse = n; v.plen = p; v.exp_cnt = 8'(c); v.exp_cg = g;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    car_sensor = 1'b0;
    enable     = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  // Pulses start (2 + DEBOUNCE) edges before the previous close so that every
  // resulting car event lands inside this window's counting range.
  task automatic drive_window(input int n, input int p);
    for (int t = 0; t < w_sel; t++) begin
      car_sensor = ((t / (p + 1)) < n) && ((t % (p + 1)) < p);
      tick();
    end
    car_sensor = 1'b0;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].rst) begin
        mon_on = 1'b0;
        sel = vecs[i].sel;
        case (sel)
          0:       begin w_sel = 10;   deb_sel = 2; end
          1:       begin w_sel = 40;   deb_sel = 2; end
          default: begin w_sel = 1000; deb_sel = 1; end
        endcase
        do_reset();
        mon_on = 1'b1;
        exp_q.push_back(9'h000);
        repeat (w_sel - 1 - deb_sel) tick();
      end
      exp_q.push_back({vecs[i].exp_cg, vecs[i].exp_cnt});
      drive_window(vecs[i].npulse, vecs[i].plen);
    end
  endtask

  task automatic finish_seg(input string name);
    repeat (deb_sel + 3) tick();
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- test ----------------
  int sum;

  initial begin
    // sel rst npulse plen -> cnt cong
    add_vec(0, 1, 2, 3,   2, 0);
    add_vec(0, 0, 1, 3,   1, 0);
    add_vec(0, 0, 2, 1,   0, 0);   // single-cycle glitches
    add_vec(0, 0, 0, 3,   0, 0);
    add_vec(0, 0, 2, 3,   2, 0);
    add_vec(1, 1, 7, 3,   7, 0);   // 5
    add_vec(1, 0, 9, 3,   9, 1);
    add_vec(1, 0, 0, 3,   0, 1);
    add_vec(1, 0, 0, 3,   0, 1);
    add_vec(1, 0, 0, 3,   0, 1);
    add_vec(1, 0, 0, 3,   0, 1);   // 10
    add_vec(1, 0, 0, 3,   0, 0);   // fifth close after congesting
    add_vec(1, 0, 8, 3,   8, 1);
    add_vec(1, 0, 0, 3,   0, 1);
    add_vec(1, 0, 0, 3,   0, 1);
    add_vec(1, 0, 0, 3,   0, 1);   // 15
    add_vec(1, 0, 0, 3,   0, 1);
    add_vec(1, 0, 5, 3,   5, 1);
    add_vec(1, 0, 4, 3,   4, 1);
    add_vec(1, 0, 3, 3,   3, 0);
    add_vec(1, 0, 7, 3,   7, 0);   // 20
    add_vec(2, 1, 300, 1, 255, 1);
    add_vec(2, 0, 0, 1,   0, 1);
    add_vec(1, 1, 9, 3,   9, 1);   // 23

    // Asynchronous reset with no clock edge in between
    #1 reset_n = 1'b0;
    #1;
    check("rst_cong_a", cong_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_wd_a", wd_a, 0);
    check("rst_state_a", st_a, 0);
    check("rst_cong_b", cong_b, 0);
    check("rst_cnt_b", cnt_b, 0);
    check("rst_state_c", st_c, 0);
    check("rst_cnt_c", cnt_c, 0);

    run_range(0, 4);

    // Disable mid-window: partial count dropped, car_count held, fresh window later
    repeat (4) tick();
    car_sensor = 1'b1; repeat (3) tick();
    car_sensor = 1'b0; repeat (3) tick();
    enable = 1'b0; tick();
    check("dis_state", st_a, 0);
    check("dis_cong", cong_a, 0);
    check("dis_wd", wd_a, 0);
    check("dis_cnt_held", cnt_a, 2);
    car_sensor = 1'b1; repeat (3) tick();
    car_sensor = 1'b0; repeat (4) tick();
    enable = 1'b1;
    exp_q.push_back(9'h000);
    tick();
    check("reen_state", st_a, 1);
    repeat (9) tick();
    check("reen_wd_early", wd_a, 0);
    tick();
    check("reen_wd", wd_a, 1);
    check("reen_cnt", cnt_a, 0);
    finish_seg("seg_a_drained");

    // Level held high for 40 cycles yields one car
    mon_on = 1'b0;
    sel = 0; w_sel = 10; deb_sel = 2;
    do_reset();
    sum = 0;
    car_sensor = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (i == 40) car_sensor = 1'b0;
      tick();
      if (wd_a) sum += int'(cnt_a);
    end
    check("held_high_cars", sum, 1);

    run_range(5, 20);
    finish_seg("seg_b_drained");
    run_range(21, 22);
    finish_seg("seg_c_drained");

    // Reset while congested drops everything without a clock edge
    run_range(23, 23);
    repeat (6) tick();
    check("pre_rst_cong", cong_b, 1);
    check("pre_rst_cnt", cnt_b, 9);
    check("pre_rst_drained", exp_q.size(), 0);
    mon_on = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_cong", cong_b, 0);
    check("async_cnt", cnt_b, 0);
    check("async_wd", wd_b, 0);
    check("async_state", st_b, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_state", st_b, 1);
    check("post_rst_cong", cong_b, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
